// File: rtl/calc_n_engine.sv
// calc_n_engine: multi-port calculator with per-port request FIFOs, a
// round-robin arbiter and a shared two-stage ALU.
//
// Ports:
//   c_clk        clock; every register updates on its rising edge
//   reset        synchronous, active-high reset
//   req_cmd_in   per-port 4-bit command, port i at [4i+3:4i]
//   req_data_in  per-port operand (op1 with the command, op2 the cycle after)
//   req_tag_in   per-port tag, captured together with the command
//   req_ready    per-port: a new command may be issued this cycle
//   out_resp     per-port response code (0 none, 1 ok, 2 error, 3 saturated)
//   out_data     per-port result
//   out_tag      per-port echoed tag
module calc_n_engine #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int SATURATE   = 0
) (
    input  logic                        c_clk,
    input  logic                        reset,
    input  logic [NUM_PORTS*4-1:0]      req_cmd_in,
    input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
    input  logic [NUM_PORTS*TAG_W-1:0]  req_tag_in,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic [NUM_PORTS*2-1:0]      out_resp,
    output logic [NUM_PORTS*DATA_W-1:0] out_data,
    output logic [NUM_PORTS*TAG_W-1:0]  out_tag
);

    localparam int SH_W   = $clog2(DATA_W);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;
    localparam logic [1:0] RESP_SAT = 2'd3;

    typedef enum logic {S_IDLE, S_WAIT_OP2} state_t;

    // Overflow/underflow result: clamp toward the violated bound, or flag error.
    function automatic logic [DATA_W+1:0] ovf_result(input logic high);
        if (SATURATE != 0)
            return {RESP_SAT, high ? {DATA_W{1'b1}} : {DATA_W{1'b0}}};
        else
            return {RESP_ERR, {DATA_W{1'b0}}};
    endfunction

    // Returns {resp, data}.
    function automatic logic [DATA_W+1:0] alu(input logic [3:0]        cmd,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic [DATA_W:0]   sum;
        logic [SH_W-1:0]   sh;
        sum = {1'b0, a} + {1'b0, b};
        sh  = b[SH_W-1:0];
        case (cmd)
            CMD_ADD: return sum[DATA_W] ? ovf_result(1'b1) : {RESP_OK, sum[DATA_W-1:0]};
            CMD_SUB: return (b <= a) ? {RESP_OK, a - b} : ovf_result(1'b0);
            CMD_SHL: return {RESP_OK, a << sh};
            CMD_SHR: return {RESP_OK, a >> sh};
            default: return {RESP_ERR, {DATA_W{1'b0}}};
        endcase
    endfunction

    state_t              state_q [NUM_PORTS];
    logic [3:0]          cap_cmd [NUM_PORTS];
    logic [TAG_W-1:0]    cap_tag [NUM_PORTS];
    logic [DATA_W-1:0]   cap_op1 [NUM_PORTS];

    logic [3:0]          fifo_cmd [NUM_PORTS][FIFO_DEPTH];
    logic [TAG_W-1:0]    fifo_tag [NUM_PORTS][FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_op1 [NUM_PORTS][FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_op2 [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr   [NUM_PORTS];
    logic [PTR_W-1:0]    rd_ptr   [NUM_PORTS];
    logic [CNT_W-1:0]    count    [NUM_PORTS];

    logic [NUM_PORTS-1:0] push, pop, fifo_empty, accept;
    logic [PORT_W-1:0]    rr_ptr, grant_idx, cand, rr_next;
    logic                 grant_vld;

    logic                 vld_p1;
    logic [PORT_W-1:0]    port_p1;
    logic [3:0]           cmd_p1;
    logic [TAG_W-1:0]     tag_p1;
    logic [DATA_W-1:0]    op1_p1, op2_p1;

    logic                 vld_p2;
    logic [PORT_W-1:0]    port_p2;
    logic [1:0]           resp_p2;
    logic [DATA_W-1:0]    data_p2;
    logic [TAG_W-1:0]     tag_p2;

    // Request side: handshake and FIFO status per port.
    always_comb begin
        push       = '0;
        fifo_empty = '0;
        req_ready  = '0;
        accept     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            push[i]       = (state_q[i] == S_WAIT_OP2);
            fifo_empty[i] = (count[i] == '0);
            req_ready[i]  = (state_q[i] == S_IDLE) && (count[i] < DEPTH_C);
            accept[i]     = req_ready[i] && (req_cmd_in[4*i +: 4] != CMD_NOP);
        end
    end

    // Round-robin search starting at rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            cand = PORT_W'((int'(rr_ptr) + off) % NUM_PORTS);
            if (!grant_vld && !fifo_empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        rr_next = (grant_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_idx + PORT_W'(1);
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            pop[i] = grant_vld && (grant_idx == PORT_W'(i));
    end

    // Control state: FSMs, FIFO pointers, arbiter pointer, pipeline valids.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= S_IDLE;
                wr_ptr[i]  <= '0;
                rd_ptr[i]  <= '0;
                count[i]   <= '0;
            end
            rr_ptr <= '0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                case (state_q[i])
                    S_IDLE:  if (accept[i]) state_q[i] <= S_WAIT_OP2;
                    default: state_q[i] <= S_IDLE;
                endcase
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
            if (grant_vld) rr_ptr <= rr_next;
            vld_p1 <= grant_vld;
            vld_p2 <= vld_p1;
        end
    end

    // Datapath: capture, FIFO storage and the two ALU stages.
    always_ff @(posedge c_clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (accept[i]) begin
                cap_cmd[i] <= req_cmd_in[4*i +: 4];
                cap_tag[i] <= req_tag_in[TAG_W*i +: TAG_W];
                cap_op1[i] <= req_data_in[DATA_W*i +: DATA_W];
            end
            if (push[i]) begin
                fifo_cmd[i][wr_ptr[i]] <= cap_cmd[i];
                fifo_tag[i][wr_ptr[i]] <= cap_tag[i];
                fifo_op1[i][wr_ptr[i]] <= cap_op1[i];
                fifo_op2[i][wr_ptr[i]] <= req_data_in[DATA_W*i +: DATA_W];
            end
        end
        // ---- stage 1: granted FIFO head ----
        port_p1 <= grant_idx;
        cmd_p1  <= fifo_cmd[grant_idx][rd_ptr[grant_idx]];
        tag_p1  <= fifo_tag[grant_idx][rd_ptr[grant_idx]];
        op1_p1  <= fifo_op1[grant_idx][rd_ptr[grant_idx]];
        op2_p1  <= fifo_op2[grant_idx][rd_ptr[grant_idx]];
        // ---- stage 2: ALU result ----
        port_p2              <= port_p1;
        tag_p2               <= tag_p1;
        {resp_p2, data_p2}   <= alu(cmd_p1, op1_p1, op2_p1);
    end

    // Only the originating port sees the result; vld_p2 masks stale data.
    always_comb begin
        out_resp = '0;
        out_data = '0;
        out_tag  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (vld_p2 && (port_p2 == PORT_W'(i))) begin
                out_resp[2*i +: 2]          = resp_p2;
                out_data[DATA_W*i +: DATA_W] = data_p2;
                out_tag[TAG_W*i +: TAG_W]   = tag_p2;
            end
        end
    end

endmodule

// File: tb/tb_calc_n_engine.sv
module tb_calc_n_engine;

    logic         c_clk = 1'b0;
    logic         reset;
    logic [15:0]  req_cmd_in;
    logic [127:0] req_data_in;
    logic [7:0]   req_tag_in;
    logic [3:0]   req_ready, s_req_ready;
    logic [7:0]   out_resp, s_out_resp;
    logic [127:0] out_data, s_out_data;
    logic [7:0]   out_tag, s_out_tag;

    int tests_run = 0;
    int failed    = 0;

    calc_n_engine #(.NUM_PORTS(4), .DATA_W(32), .TAG_W(2), .FIFO_DEPTH(4), .SATURATE(0)) dut (
        .c_clk(c_clk), .reset(reset),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .req_ready(req_ready), .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag)
    );

    calc_n_engine #(.NUM_PORTS(4), .DATA_W(32), .TAG_W(2), .FIFO_DEPTH(4), .SATURATE(1)) dut_s (
        .c_clk(c_clk), .reset(reset),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .req_ready(s_req_ready), .out_resp(s_out_resp), .out_data(s_out_data), .out_tag(s_out_tag)
    );

    always #5 c_clk = ~c_clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic clear_in();
        req_cmd_in  = '0;
        req_data_in = '0;
        req_tag_in  = '0;
    endtask

    task automatic set_port(input int p, input logic [3:0] c, input logic [31:0] d, input logic [1:0] t);
        req_cmd_in[4*p +: 4]   = c;
        req_data_in[32*p +: 32] = d;
        req_tag_in[2*p +: 2]   = t;
    endtask

    task automatic issue(input int p, input logic [3:0] c, input logic [31:0] op1,
                         input logic [31:0] op2, input logic [1:0] t);
        set_port(p, c, op1, t);
        tick();
        set_port(p, 4'h0, op2, 2'h0);
        tick();
        set_port(p, 4'h0, 32'h0, 2'h0);
    endtask

    // Leaves the response on the outputs (two edges after op2).
    task automatic run1(input int p, input logic [3:0] c, input logic [31:0] op1,
                        input logic [31:0] op2, input logic [1:0] t);
        issue(p, c, op1, op2, t);
        tick();
        tick();
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    int          order2 [4] = '{2, 3, 0, 1};
    int          phase [4];
    int          seq [4];
    logic        go [4];
    logic [1:0]  exp_tag_q [$];
    logic [31:0] exp_data_q [$];
    int          bp_accepted, bp_seen;
    logic        saw_low;
    logic [1:0]  e_tag;
    logic [31:0] e_data;

    initial begin
        // Reset with a command held on port 0: ready all-ones, nothing accepted.
        clear_in();
        reset = 1'b1;
        set_port(0, 4'h1, 32'h11, 2'h1);
        tick();
        tick();
        chk("rst_ready", {124'h0, req_ready}, 128'hF);
        chk("rst_ready_s", {124'h0, s_req_ready}, 128'hF);
        chk("rst_resp", {120'h0, out_resp}, 128'h0);
        chk("rst_data", out_data, 128'h0);
        chk("rst_tag", {120'h0, out_tag}, 128'h0);
        clear_in();
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_no_resp", {120'h0, out_resp}, 128'h0);

        // Single add on port 0, exact latency.
        issue(0, 4'h1, 32'h30, 32'h20, 2'h1);
        tick();
        chk("add_early", {120'h0, out_resp}, 128'h0);
        tick();
        chk("add_resp", {120'h0, out_resp}, 128'h01);
        chk("add_data", out_data, 128'h50);
        chk("add_tag", {120'h0, out_tag}, 128'h01);
        tick();
        chk("add_one_cycle", {120'h0, out_resp}, 128'h0);

        // Error vs saturation on port 1.
        run1(1, 4'h1, 32'hFFFF_FFFF, 32'h1, 2'h2);
        chk("add_ovf_resp", {126'h0, out_resp[3:2]}, 128'h2);
        chk("add_ovf_data", {96'h0, out_data[63:32]}, 128'h0);
        chk("add_sat_resp", {126'h0, s_out_resp[3:2]}, 128'h3);
        chk("add_sat_data", {96'h0, s_out_data[63:32]}, 128'hFFFF_FFFF);
        chk("add_sat_tag", {126'h0, s_out_tag[3:2]}, 128'h2);
        run1(1, 4'h2, 32'h5, 32'h6, 2'h3);
        chk("sub_unf_resp", {126'h0, out_resp[3:2]}, 128'h2);
        chk("sub_unf_data", {96'h0, out_data[63:32]}, 128'h0);
        chk("sub_sat_resp", {126'h0, s_out_resp[3:2]}, 128'h3);
        chk("sub_sat_data", {96'h0, s_out_data[63:32]}, 128'h0);
        run1(1, 4'h3, 32'h7, 32'h1, 2'h1);
        chk("inv_resp", {126'h0, out_resp[3:2]}, 128'h2);
        chk("inv_data", {96'h0, out_data[63:32]}, 128'h0);
        run1(1, 4'h2, 32'h9, 32'h9, 2'h0);
        chk("sub_eq_resp", {126'h0, out_resp[3:2]}, 128'h1);

        // Shifts on port 3.
        run1(3, 4'h5, 32'h1, 32'h21, 2'h2);
        chk("shl_resp", {120'h0, out_resp}, 128'h40);
        chk("shl_data", out_data, {32'h2, 96'h0});
        run1(3, 4'h6, 32'h8000_0000, 32'd31, 2'h1);
        chk("shr_resp", {120'h0, out_resp}, 128'h40);
        chk("shr_data", out_data, {32'h1, 96'h0});
        chk("shr_tag", {120'h0, out_tag}, 128'h40);

        // Arbitration: simultaneous round from pointer 0.
        do_reset();
        for (int p = 0; p < 4; p++) set_port(p, 4'h1, 32'(32'h10 * (p + 1)), 2'(p));
        tick();
        for (int p = 0; p < 4; p++) set_port(p, 4'h0, 32'h1, 2'h0);
        tick();
        clear_in();
        tick();
        for (int p = 0; p < 4; p++) begin
            tick();
            chk("arb1_resp", {120'h0, out_resp}, 128'h1 << (2 * p));
            chk("arb1_tag", {120'h0, out_tag}, 128'(p) << (2 * p));
            chk("arb1_data", out_data, 128'(32'h10 * (p + 1) + 1) << (32 * p));
        end
        tick();
        chk("arb1_idle", {120'h0, out_resp}, 128'h0);

        // Move the pointer to 2 with a lone port-1 grant, then a second round.
        run1(1, 4'h1, 32'h7, 32'h1, 2'h3);
        chk("arb_p1_resp", {120'h0, out_resp}, 128'h04);
        for (int p = 0; p < 4; p++) set_port(p, 4'h1, 32'(32'h10 * (p + 1)), 2'(p));
        tick();
        for (int p = 0; p < 4; p++) set_port(p, 4'h0, 32'h1, 2'h0);
        tick();
        clear_in();
        tick();
        for (int k = 0; k < 4; k++) begin
            int p;
            p = order2[k];
            tick();
            chk("arb2_resp", {120'h0, out_resp}, 128'h1 << (2 * p));
            chk("arb2_tag", {120'h0, out_tag}, 128'(p) << (2 * p));
        end

        // Backpressure: all ports hammer the shared ALU so port 2 fills.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            phase[p] = 0;
            seq[p]   = 0;
            go[p]    = 1'b0;
        end
        bp_accepted = 0;
        bp_seen     = 0;
        saw_low     = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            for (int p = 0; p < 4; p++) begin
                if (phase[p] == 1) begin
                    set_port(p, 4'h0, 32'h1, 2'h0);
                    go[p] = 1'b0;
                end else if (cyc < 40) begin
                    set_port(p, 4'h1, 32'(32'h100 + seq[p]), 2'(seq[p]));
                    go[p] = req_ready[p];
                    if (p == 2 && !req_ready[p]) saw_low = 1'b1;
                    if (p == 2 && req_ready[p]) begin
                        exp_tag_q.push_back(2'(seq[p]));
                        exp_data_q.push_back(32'(32'h101 + seq[p]));
                        bp_accepted++;
                    end
                end else begin
                    set_port(p, 4'h0, 32'h0, 2'h0);
                    go[p] = 1'b0;
                end
            end
            tick();
            for (int p = 0; p < 4; p++) begin
                if (phase[p] == 1) phase[p] = 0;
                else if (go[p]) begin
                    phase[p] = 1;
                    seq[p]++;
                end
            end
            if (out_resp[5:4] != 2'b00) begin
                bp_seen++;
                if (exp_tag_q.size() == 0) begin
                    chk("bp_extra_resp", {126'h0, out_resp[5:4]}, 128'h0);
                end else begin
                    e_tag  = exp_tag_q.pop_front();
                    e_data = exp_data_q.pop_front();
                    chk("bp_resp", {126'h0, out_resp[5:4]}, 128'h1);
                    chk("bp_tag", {126'h0, out_tag[5:4]}, {126'h0, e_tag});
                    chk("bp_data", {96'h0, out_data[95:64]}, {96'h0, e_data});
                end
            end
        end
        clear_in();
        chk("bp_ready_dropped", {127'h0, saw_low}, 128'h1);
        chk("bp_count", 128'(bp_seen), 128'(bp_accepted));
        chk("bp_ready_back", {124'h0, req_ready}, 128'hF);

        // Reset mid-flight: pending add on port 0 plus a half-issued port-1 request.
        issue(0, 4'h1, 32'h5, 32'h6, 2'h2);
        set_port(1, 4'h1, 32'h9, 2'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_in();
        chk("mid_rst_ready", {124'h0, req_ready}, 128'hF);
        for (int c = 0; c < 5; c++) begin
            chk("mid_rst_resp", {120'h0, out_resp}, 128'h0);
            chk("mid_rst_data", out_data, 128'h0);
            tick();
        end
        chk("mid_rst_tag", {120'h0, out_tag}, 128'h0);
        chk("mid_rst_ready2", {124'h0, req_ready}, 128'hF);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/calc_n_engine.md
# calc_n_engine

Parametrised successor to the four-port calc2 calculator. It has NUM_PORTS request ports, each with its own request FIFO, and a shared two-stage ALU fed by a round-robin arbiter. Each port gets explicit flow control (`req_ready`) and an optional saturating arithmetic mode. Each result returns to the port that issued the request, carrying the request's tag.

## Interface
- NUM_PORTS, 4: number of request/response ports (1..8).
- DATA_W, 32: operand/result width (power of two, ≥8).
- TAG_W, 2: tag width.
- FIFO_DEPTH, 4: entries per port request FIFO (power of two, ≥2).
- SATURATE, 0: 1 = add overflow / sub underflow saturates (resp 3) instead of erroring (resp 2).
- c_clk  in  1  clock. One clock domain; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_cmd_in  in  NUM_PORTS*4  per-port command; port i = bits [4i+3:4i].
- req_data_in  in  NUM_PORTS*DATA_W  per-port operand.
- req_tag_in  in  NUM_PORTS*TAG_W  per-port tag.
- req_ready  out  NUM_PORTS  port i may start a request this cycle.
- out_resp  out  NUM_PORTS*2  per-port response code.
- out_data  out  NUM_PORTS*DATA_W  per-port result.
- out_tag  out  NUM_PORTS*TAG_W  per-port echoed tag.

## Operation
- Commands: 0 = no-op, 1 = add, 2 = sub, 5 = shl, 6 = shr. Any other nonzero value is invalid.
- Response codes: 0 = none, 1 = success, 2 = overflow/underflow/invalid, 3 = saturated.
- Request protocol (per port FSM, two states):
  - IDLE: when cmd≠0 and req_ready=1, capture cmd, tag and op1, then go to WAIT_OP2. cmd≠0 with req_ready=0 is ignored; the source must hold it.
  - WAIT_OP2: the next cycle's data_in is op2, and cmd/tag in that cycle are ignored. Write {cmd,tag,op1,op2} to the FIFO and return to IDLE.
- req_ready[i] = (state==IDLE) && (FIFO count < FIFO_DEPTH). Space is therefore guaranteed when op2 arrives.
- Arbiter:
  - Round-robin over non-empty FIFOs, one grant per cycle.
  - The priority pointer resets to port 0 and moves to granted+1 (mod NUM_PORTS) after each grant.
  - It does not move when nothing is granted.
- ALU stage 1 (granted entry registered) computes results as follows. All arithmetic is unsigned DATA_W.
  - add: carry-out=0 → sum, resp 1. Carry-out=1 → SATURATE ? all-ones, resp 3 : 0, resp 2.
  - sub: op2≤op1 → op1−op2, resp 1. Otherwise → SATURATE ? 0, resp 3 : 0, resp 2.
  - shl / shr: op1 shifted by op2[log2(DATA_W)-1:0], zero fill, resp 1. Upper op2 bits are ignored.
  - invalid: data 0, resp 2.
- Stage 2 drives out_* of the originating port only, for exactly one cycle.
  - Every other port's out_resp/out_data/out_tag is 0 in that cycle.
  - At most one port has out_resp≠0 in any cycle.
- Ordering: responses on a given port come out in request order. Across ports, order follows arbitration.
- Reset values: all out_resp/out_data/out_tag = 0; req_ready = all-ones; FIFOs empty; FSMs in IDLE; pointer = 0.

## Timing
- Let op2 be sampled at edge k, and assume the arbiter is uncontended.
  - Edge k+1: the entry is popped into stage 1.
  - Edge k+2: out_* registered, so the response is valid in the cycle after edge k+2.
  - Minimum latency is therefore 2 cycles from op2.
- Back-to-back requests on one port: a new cmd is accepted on the cycle after op2. Peak rate is one request per 2 cycles per port.
- Shared ALU throughput is one result per cycle. If all ports are saturated, each port gets one grant per NUM_PORTS cycles.
- FIFO full: req_ready drops in the cycle after the write that fills it.
  - Simultaneous pop and op2 write: count is unchanged.
  - Simultaneous pop on a full FIFO: req_ready rises the next cycle.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Reset asserted at any edge:
  - FIFOs, pipeline, FSMs and pointer clear at that edge.
  - In-flight requests are discarded and produce no response; a half-issued request (op1 only) is dropped.
  - All outputs read 0 in the following cycle.
- Reset held high: req_ready reads all-ones, but inputs are ignored.

## Test plan
- Port 0: add op1=0x30, op2=0x20, tag 1 → port 0 shows resp 1, data 0x50, tag 1, exactly 2 cycles after op2; other ports all zero.
- Error vs saturation:
  - SATURATE=0: add 0xFFFFFFFF+1 → resp 2, data 0. sub 0x5−0x6 → resp 2, data 0. cmd 4'h3 → resp 2, data 0.
  - SATURATE=1: the same add → resp 3, data 0xFFFFFFFF; the same sub → resp 3, data 0.
- Shifts: shl 0x1 by 0x21 → data 0x2 (low 5 bits used). shr 0x80000000 by 31 → data 0x1. Both resp 1.
- Arbitration: all 4 ports issue add (tag = port index) on the same cycle → responses on consecutive cycles in order port 0, 1, 2, 3. A second simultaneous round starts at the port after the last grant.
- Backpressure: with the ALU blocked, port 2 issues FIFO_DEPTH requests → req_ready[2]=0. A further cmd is ignored until a pop, and every accepted request later completes in order with the correct tag.
- Reset mid-flight: assert reset the cycle after op2 of a pending add → no response ever appears; outputs are 0 and req_ready is all-ones after reset deasserts.
